adc_frame_deserializer: RTL and testbench



---
 rtl/adc_frame_deserializer_if.sv | 23 ++
 rtl/adc_frame_deserializer.sv | 133 +++++++++++++
 tb/tb_adc_frame_deserializer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/adc_frame_deserializer_if.sv
// Lane-side bundle for adc_frame_deserializer: ISERDES words in, alignment/sample results out.
// The master modport is the ISERDES/consumer side; the slave modport is the deserializer.
interface adc_frame_deserializer_if;
  logic [7:0]  frame_in;
  logic [7:0]  d0_in;
  logic [7:0]  d1_in;
  logic        bitslip_out;
  logic        aligned_out;
  logic [15:0] sample_out;
  logic        valid_out;
  logic        align_err_out;
  logic [7:0]  lost_cnt_out;

  modport master (
    output frame_in, d0_in, d1_in,
    input  bitslip_out, aligned_out, sample_out, valid_out, align_err_out, lost_cnt_out
  );

  modport slave (
    input  frame_in, d0_in, d1_in,
    output bitslip_out, aligned_out, sample_out, valid_out, align_err_out, lost_cnt_out
  );
endinterface

// File: rtl/adc_frame_deserializer.sv
// Frame-lane bitslip alignment and 2-lane sample reassembly for a 16-bit LVDS ADC.
// Define ADC_OFFSET_BIN_EN when the ADC delivers offset binary (MSB inverted to two's complement).
//
// state  | meaning
// CHECK  | counting consecutive frame matches toward lock
// SLIP   | one-cycle bitslip pulse to the ISERDES
// SETTLE | waiting for the slipped lanes to settle, frame ignored
// LOCKED | aligned; matching frames produce samples
module adc_frame_deserializer #(
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_SLIPS     = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  adc_frame_deserializer_if.slave adc_if
);
  localparam int unsigned MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    SLIP_LIMIT  = 8'(MAX_SLIPS);

  typedef enum logic [1:0] {ST_CHECK, ST_SLIP, ST_SETTLE, ST_LOCKED} state_t;

  state_t      state_q, state_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]  slip_cnt_q, slip_cnt_d;
  logic [7:0]  lost_cnt_q, lost_cnt_d;
  logic        err_q, err_d;
  logic        valid_q;
  logic [15:0] sample_q;
  logic [15:0] assembled;
  logic        frame_ok;

  assign frame_ok = (adc_if.frame_in == FRAME_PATTERN);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_CHECK;
      match_cnt_q  <= '0;
      settle_cnt_q <= '0;
      slip_cnt_q   <= '0;
      lost_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      lost_cnt_q   <= lost_cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    settle_cnt_d = settle_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    lost_cnt_d   = lost_cnt_q;
    err_d        = err_q;
    case (state_q)
      ST_CHECK: begin
        if (!frame_ok) begin
          match_cnt_d = '0;
          state_d     = ST_SLIP;
        end else if (match_cnt_q == MATCH_LAST) begin
          match_cnt_d = '0;
          slip_cnt_d  = '0;
          state_d     = ST_LOCKED;
        end else begin
          match_cnt_d = match_cnt_q + 1'b1;
        end
      end
      ST_SLIP: begin
        if (slip_cnt_q != 8'hFF) slip_cnt_d = slip_cnt_q + 8'd1;
        // Error only flags the condition; the search keeps slipping.
        if (slip_cnt_d >= SLIP_LIMIT) err_d = 1'b1;
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!frame_ok) begin
          match_cnt_d = '0;
          if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
          state_d = ST_CHECK;
        end
      end
      default: state_d = ST_CHECK;
    endcase
  end

  always_comb begin
    assembled = '0;
    for (int k = 0; k < 8; k++) begin
      assembled[2*k]   = adc_if.d0_in[k];
      assembled[2*k+1] = adc_if.d1_in[k];
    end
`ifdef ADC_OFFSET_BIN_EN
    assembled[15] = ~assembled[15];
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      valid_q <= (state_q == ST_LOCKED) && frame_ok;
      if ((state_q == ST_LOCKED) && frame_ok) sample_q <= assembled;
    end
  end

  always_comb begin
    adc_if.bitslip_out   = (state_q == ST_SLIP);
    adc_if.aligned_out   = (state_q == ST_LOCKED);
    adc_if.valid_out     = valid_q;
    adc_if.sample_out    = sample_q;
    adc_if.align_err_out = err_q;
    adc_if.lost_cnt_out  = lost_cnt_q;
  end
endmodule

// File: tb/tb_adc_frame_deserializer.sv
// Directed bench for adc_frame_deserializer: lock, bitslip search, sample packing, loss, reset.
module tb_adc_frame_deserializer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  adc_frame_deserializer_if adc_if ();

  adc_frame_deserializer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .adc_if (adc_if)
  );

  always #5 clk_in = ~clk_in;

`ifdef ADC_OFFSET_BIN_EN
  localparam logic [15:0] EXP_A = 16'hD555;
  localparam logic [15:0] EXP_B = 16'h2AAA;
  localparam logic [15:0] EXP_C = 16'hCEB1;
`else
  localparam logic [15:0] EXP_A = 16'h5555;
  localparam logic [15:0] EXP_B = 16'hAAAA;
  localparam logic [15:0] EXP_C = 16'h4EB1;
`endif

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bitslip"}, 32'(adc_if.bitslip_out), 32'd0);
    chk({tag, "_aligned"}, 32'(adc_if.aligned_out), 32'd0);
    chk({tag, "_valid"},   32'(adc_if.valid_out), 32'd0);
    chk({tag, "_sample"},  32'(adc_if.sample_out), 32'd0);
    chk({tag, "_err"},     32'(adc_if.align_err_out), 32'd0);
    chk({tag, "_lost"},    32'(adc_if.lost_cnt_out), 32'd0);
  endtask

  // Caller has put the first matching frame on the bus just after an edge in CHECK.
  task automatic expect_lock(input string tag);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk({tag, "_pre_aligned"}, 32'(adc_if.aligned_out), 32'd0);
      chk({tag, "_pre_bitslip"}, 32'(adc_if.bitslip_out), 32'd0);
    end
    tick();
    chk({tag, "_aligned"}, 32'(adc_if.aligned_out), 32'd1);
    chk({tag, "_valid_lag"}, 32'(adc_if.valid_out), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(adc_if.valid_out), 32'd1);
    chk({tag, "_still_aligned"}, 32'(adc_if.aligned_out), 32'd1);
  endtask

  initial begin
    int pulses;
    logic exp_slip;

    adc_if.frame_in = 8'h00;
    adc_if.d0_in    = 8'h00;
    adc_if.d1_in    = 8'h00;
    rst_in = 1'b1;
    tick();
    chk_reset_outputs("por");

    // Clean frame from reset: lock after 16 matches, no slips.
    rst_in = 1'b0;
    adc_if.frame_in = 8'hF0;
    expect_lock("lock0");

    adc_if.d0_in = 8'hFF; adc_if.d1_in = 8'h00;
    tick();
    chk("sample_d0_ones", 32'(adc_if.sample_out), 32'(EXP_A));
    chk("sample_d0_valid", 32'(adc_if.valid_out), 32'd1);
    adc_if.d0_in = 8'h00; adc_if.d1_in = 8'hFF;
    tick();
    chk("sample_d1_ones", 32'(adc_if.sample_out), 32'(EXP_B));
    adc_if.d0_in = 8'hA5; adc_if.d1_in = 8'h3C;
    tick();
    chk("sample_mixed", 32'(adc_if.sample_out), 32'(EXP_C));

    // Single bad frame drops lock; sample holds; pattern resumes and relocks without slipping.
    adc_if.frame_in = 8'hE1;
    adc_if.d0_in = 8'h11; adc_if.d1_in = 8'h22;
    tick();
    chk("loss_aligned", 32'(adc_if.aligned_out), 32'd0);
    chk("loss_valid", 32'(adc_if.valid_out), 32'd0);
    chk("loss_lost_cnt", 32'(adc_if.lost_cnt_out), 32'd1);
    chk("loss_sample_hold", 32'(adc_if.sample_out), 32'(EXP_C));
    adc_if.frame_in = 8'hF0;
    expect_lock("relock");
    chk("relock_lost_cnt", 32'(adc_if.lost_cnt_out), 32'd1);
    chk("relock_err", 32'(adc_if.align_err_out), 32'd0);

    // Reset while LOCKED.
    rst_in = 1'b1;
    tick();
    chk_reset_outputs("rst_locked");
    rst_in = 1'b0;
    expect_lock("lock_after_rst");

    // Rotated frame: three slips 6 cycles apart, then lock.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    adc_if.frame_in = 8'h1E;
    pulses = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      exp_slip = (t == 1) || (t == 7) || (t == 13);
      if (adc_if.bitslip_out) pulses++;
      chk("slip3_bitslip", 32'(adc_if.bitslip_out), 32'(exp_slip));
      chk("slip3_aligned", 32'(adc_if.aligned_out), (t >= 34) ? 32'd1 : 32'd0);
      if (t == 13) adc_if.frame_in = 8'hF0;
    end
    chk("slip3_count", 32'(pulses), 32'd3);
    chk("slip3_err", 32'(adc_if.align_err_out), 32'd0);

    // Frame never matches: pulses every 6 cycles, error sets on the 8th slip.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    adc_if.frame_in = 8'h00;
    for (int t = 1; t <= 57; t++) begin
      tick();
      chk("nolock_bitslip", 32'(adc_if.bitslip_out), ((t - 1) % 6 == 0) ? 32'd1 : 32'd0);
      chk("nolock_err", 32'(adc_if.align_err_out), (t >= 44) ? 32'd1 : 32'd0);
      chk("nolock_aligned", 32'(adc_if.aligned_out), 32'd0);
    end

    // Now in SETTLE: reset clears everything including the sticky error.
    rst_in = 1'b1;
    tick();
    chk_reset_outputs("rst_settle");
    rst_in = 1'b0;
    adc_if.frame_in = 8'hF0;
    expect_lock("lock_after_settle_rst");
    chk("final_err", 32'(adc_if.align_err_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
